// File: rtl/dmi_pkg.sv
// dmi_pkg: shared DMI types and constants for the DMI arbiter slice.
//   dmi_op_e    : DMI request opcodes (NOP/READ/WRITE)
//   dmi_resp_e  : DMI response codes (SUCCESS/FAILED/BUSY)
//   arb_state_e : arbiter FSM states
//   DMI_ADDR_W / DMI_DATA_W : default DMI field widths
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_SUCCESS = 2'd0,
    DMI_RESP_FAILED  = 2'd2,
    DMI_RESP_BUSY    = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_RESP  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dmi_rr_pick.sv
// dmi_rr_pick: combinational round-robin picker.
//   i_valid [N_REQ]  per-requester valid vector
//   i_last  [ID_W]   index granted last; search starts just after it, wrapping
//   o_idx   [ID_W]   chosen requester (0 when nothing valid)
//   o_any   [1]      at least one requester valid
module dmi_rr_pick #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_last,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  logic [ID_W-1:0] w_cand;

  // Scan from the farthest offset down to the nearest so the closest
  // valid requester after i_last is the last one written and wins.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(i_last) + k) % N_REQ);
      if (i_valid[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one DMI request/response channel between N_REQ debug
// transports. Round-robin grant, one transaction in flight, response routed
// back to the requester that issued the request.
//
// Optional feature macro: DMI_ARB_TIMEOUT_EN
//   defined   : response watchdog; after TIMEOUT_CYCLES in RESP a synthetic
//               FAILED response is returned and a late response is drained.
//   undefined : RESP waits indefinitely, no DRAIN state reached.
//
// Ports:
//   clk, reset (sync, active high)
//   req_valid/req_ready/req_addr/req_op/req_data   : requester side, packed per index
//   resp_valid/resp_ready/resp_resp/resp_data      : per-requester response, shared bus
//   dmi_req_*  / dmi_resp_*                        : downstream debug module channel
//   grant_id : current/last granted requester, busy : not IDLE
//
// state | meaning
// IDLE  | no transaction; pick next requester round-robin
// REQ   | request of grant_id presented downstream
// RESP  | waiting for downstream response, routed to grant_id
// DRAIN | after timeout: swallow one late response (watchdog build only)
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter  int N_REQ          = 2,
  parameter  int ADDR_W         = DMI_ADDR_W,
  parameter  int DATA_W         = DMI_DATA_W,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*2-1:0]      req_op,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [1:0]              resp_resp,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    dmi_req_valid,
  input  logic                    dmi_req_ready,
  output logic [ADDR_W-1:0]       dmi_req_addr,
  output logic [1:0]              dmi_req_op,
  output logic [DATA_W-1:0]       dmi_req_data,
  input  logic                    dmi_resp_valid,
  output logic                    dmi_resp_ready,
  input  logic [1:0]              dmi_resp_resp,
  input  logic [DATA_W-1:0]       dmi_resp_data,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  arb_state_e      r_state, w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_pick;
  logic            w_any;
  logic            w_resp_hs;
  logic            w_grant_rdy;

  dmi_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  // Request field mux and granted requester's resp_ready.
  always_comb begin
    dmi_req_addr = '0;
    dmi_req_op   = '0;
    dmi_req_data = '0;
    w_grant_rdy  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == r_grant) begin
        dmi_req_addr = req_addr[i*ADDR_W +: ADDR_W];
        dmi_req_op   = req_op[i*2 +: 2];
        dmi_req_data = req_data[i*DATA_W +: DATA_W];
        w_grant_rdy  = resp_ready[i];
      end
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_to;

  assign w_to = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Cleared on every state change (so on entering RESP and DRAIN),
  // otherwise counts up and saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != w_state_nxt) begin
      r_cnt <= '0;
    end else if (!w_to) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= ID_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_any) begin
        r_grant <= w_pick;
      end
      if (w_resp_hs) begin
        r_last <= r_grant;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = '0;
    resp_valid     = '0;
    dmi_req_valid  = 1'b0;
    dmi_resp_ready = 1'b0;
    resp_resp      = dmi_resp_resp;
    resp_data      = dmi_resp_data;
    w_resp_hs      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) w_state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        dmi_req_valid      = 1'b1;
        req_ready[r_grant] = dmi_req_ready;
        if (dmi_req_ready) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
`ifdef DMI_ARB_TIMEOUT_EN
        if (w_to) begin
          // Synthetic failure; downstream stays held off until DRAIN.
          resp_valid[r_grant] = 1'b1;
          resp_resp           = DMI_RESP_FAILED;
          resp_data           = '0;
          if (w_grant_rdy) begin
            w_resp_hs   = 1'b1;
            w_state_nxt = ARB_DRAIN;
          end
        end else
`endif
        begin
          resp_valid[r_grant] = dmi_resp_valid;
          dmi_resp_ready      = w_grant_rdy;
          if (dmi_resp_valid && w_grant_rdy) begin
            w_resp_hs   = 1'b1;
            w_state_nxt = ARB_IDLE;
          end
        end
      end
`ifdef DMI_ARB_TIMEOUT_EN
      ARB_DRAIN: begin
        dmi_resp_ready = 1'b1;
        if (dmi_resp_valid || w_to) w_state_nxt = ARB_IDLE;
      end
`endif
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_dmi_arbiter.sv
module tb_dmi_arbiter;
  import dmi_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int IDW = 1;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_op;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [1:0]      resp_resp;
  logic [DW-1:0]   resp_data;
  logic            dmi_req_valid;
  logic            dmi_req_ready;
  logic [AW-1:0]   dmi_req_addr;
  logic [1:0]      dmi_req_op;
  logic [DW-1:0]   dmi_req_data;
  logic            dmi_resp_valid;
  logic            dmi_resp_ready;
  logic [1:0]      dmi_resp_resp;
  logic [DW-1:0]   dmi_resp_data;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  dmi_arbiter #(
    .N_REQ          (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_op         (req_op),
    .req_data       (req_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_resp      (resp_resp),
    .resp_data      (resp_data),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_op     (dmi_req_op),
    .dmi_req_data   (dmi_req_data),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_resp  (dmi_resp_resp),
    .dmi_resp_data  (dmi_resp_data),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int            id;
    logic [1:0]    code;
    logic [DW-1:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [1:0] op, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_op[i*2 +: 2]     = op;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic push_req(input int i, input logic [AW-1:0] a,
                          input logic [1:0] op, input logic [DW-1:0] d);
    req_t e;
    e.id = i; e.addr = a; e.op = op; e.data = d;
    exp_req_q.push_back(e);
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    req_valid      = '0;
    req_addr       = '0;
    req_op         = '0;
    req_data       = '0;
    resp_ready     = '0;
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp_resp  = '0;
    dmi_resp_data  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Downstream side of one transaction: accept the request after rdy_delay
  // stalled cycles, answer it, hold resp_ready low for rsp_delay cycles.
  task automatic serve_txn(input int rdy_delay, input int rsp_delay,
                           input logic [DW-1:0] rdata, input logic [1:0] rcode,
                           output int waited);
    req_t         e;
    rsp_t         r;
    logic [N-1:0] m;
    waited = 0;
    #1;
    while (dmi_req_valid !== 1'b1 && waited < 20) begin
      step(); #1; waited++;
    end
    checks++;
    if (dmi_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_wait dmi_req_valid=%b required 1 within 20 cycles", dmi_req_valid);
      return;
    end
    checks++;
    if (exp_req_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty unexpected request addr=%h required none", dmi_req_addr);
      return;
    end
    e = exp_req_q.pop_front();
    m = '0; m[e.id] = 1'b1;
    checks++;
    if (int'(grant_id) !== e.id || dmi_req_addr !== e.addr || dmi_req_op !== e.op ||
        dmi_req_data !== e.data) begin
      errors++;
      $display("FAIL req_fields got id=%0d addr=%h op=%0d data=%h required id=%0d addr=%h op=%0d data=%h",
               grant_id, dmi_req_addr, dmi_req_op, dmi_req_data, e.id, e.addr, e.op, e.data);
    end
    for (int k = 0; k < rdy_delay; k++) begin
      dmi_req_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== '0 || dmi_req_valid !== 1'b1 || dmi_req_addr !== e.addr ||
          dmi_req_data !== e.data || int'(grant_id) !== e.id) begin
        errors++;
        $display("FAIL req_stall cyc=%0d req_ready=%b valid=%b addr=%h id=%0d required ready=00 valid=1 addr=%h id=%0d",
                 k, req_ready, dmi_req_valid, dmi_req_addr, grant_id, e.addr, e.id);
      end
      step();
    end
    dmi_req_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== m) begin
      errors++;
      $display("FAIL req_ready got %b required %b", req_ready, m);
    end
    step();
    dmi_req_ready  = 1'b0;
    r.id = e.id; r.code = rcode; r.data = rdata;
    exp_rsp_q.push_back(r);
    dmi_resp_valid = 1'b1;
    dmi_resp_resp  = rcode;
    dmi_resp_data  = rdata;
    resp_ready     = '0;
    for (int k = 0; k < rsp_delay; k++) begin
      #1;
      checks++;
      if (dmi_resp_ready !== 1'b0 || resp_valid !== m || dmi_req_valid !== 1'b0 ||
          int'(grant_id) !== e.id) begin
        errors++;
        $display("FAIL resp_stall cyc=%0d dmi_resp_ready=%b resp_valid=%b dmi_req_valid=%b id=%0d required 0 %b 0 %0d",
                 k, dmi_resp_ready, resp_valid, dmi_req_valid, grant_id, m, e.id);
      end
      step();
    end
    resp_ready       = '0;
    resp_ready[e.id] = 1'b1;
    #1;
    r = exp_rsp_q.pop_front();
    checks++;
    if (resp_valid !== m || resp_data !== r.data || resp_resp !== r.code ||
        dmi_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp got valid=%b data=%h resp=%0d dmi_resp_ready=%b required valid=%b data=%h resp=%0d ready=1",
               resp_valid, resp_data, resp_resp, dmi_resp_ready, m, r.data, r.code);
    end
    step();
    dmi_resp_valid = 1'b0;
    resp_ready     = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL idle_gap busy=%b resp_valid=%b required 0 00", busy, resp_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b required 0", busy);
    end
    checks++;
    if (grant_id !== '0) begin
      errors++; $display("FAIL rst_grant got %0d required 0", grant_id);
    end
    checks++;
    if (dmi_req_valid !== 1'b0 || dmi_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_dmi got valid=%b resp_ready=%b required 0 0", dmi_req_valid, dmi_resp_ready);
    end
    checks++;
    if (req_ready !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL rst_req got req_ready=%b resp_valid=%b required 00 00", req_ready, resp_valid);
    end
  endtask

  task automatic test_basic();
    int w;
    apply_reset();
    set_req(0, 1'b1, 7'h11, DMI_OP_READ, 32'h0);
    push_req(0, 7'h11, DMI_OP_READ, 32'h0);
    #1;
    checks++;
    if (dmi_req_valid !== 1'b0 || req_ready !== '0 || dmi_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs got valid=%b req_ready=%b resp_ready=%b required 0 00 0",
               dmi_req_valid, req_ready, dmi_resp_ready);
    end
    serve_txn(0, 0, 32'hDEADBEEF, DMI_RESP_SUCCESS, w);
    set_req(0, 1'b0, 7'h0, DMI_OP_NOP, 32'h0);
    checks++;
    if (w !== 1) begin
      errors++; $display("FAIL first_latency got %0d cycles required 1", w);
    end
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    set_req(0, 1'b1, 7'h20, DMI_OP_WRITE, 32'hA5A5_0000);
    set_req(1, 1'b1, 7'h30, DMI_OP_READ,  32'h0000_5A5A);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_req(0, 7'h20, DMI_OP_WRITE, 32'hA5A5_0000);
      else            push_req(1, 7'h30, DMI_OP_READ,  32'h0000_5A5A);
    end
    for (int k = 0; k < 4; k++) begin
      serve_txn(0, 0, 32'h100 + k, DMI_RESP_SUCCESS, w);
    end
    req_valid = '0;
  endtask

  task automatic test_req_stall();
    int w;
    // last grant was 1, so 0 wins even though 1 is also waiting
    set_req(0, 1'b1, 7'h05, DMI_OP_WRITE, 32'h1234_5678);
    set_req(1, 1'b1, 7'h06, DMI_OP_READ,  32'h0);
    push_req(0, 7'h05, DMI_OP_WRITE, 32'h1234_5678);
    serve_txn(5, 0, 32'h0, DMI_RESP_SUCCESS, w);
    set_req(0, 1'b0, 7'h0, DMI_OP_NOP, 32'h0);
  endtask

  task automatic test_resp_stall();
    int w;
    push_req(1, 7'h06, DMI_OP_READ, 32'h0);
    serve_txn(0, 3, 32'hCAFE_F00D, DMI_RESP_BUSY, w);
    set_req(1, 1'b0, 7'h0, DMI_OP_NOP, 32'h0);
  endtask

  task automatic test_back_to_back();
    int w;
    set_req(1, 1'b1, 7'h41, DMI_OP_READ, 32'h0);
    for (int k = 0; k < 3; k++) push_req(1, 7'h41, DMI_OP_READ, 32'h0);
    for (int k = 0; k < 3; k++) begin
      serve_txn(0, 0, 32'h2000 + k, DMI_RESP_SUCCESS, w);
      checks++;
      if (w !== 1) begin
        errors++; $display("FAIL b2b_gap txn=%0d got %0d cycles required 1", k, w);
      end
    end
    set_req(1, 1'b0, 7'h0, DMI_OP_NOP, 32'h0);
  endtask

  task automatic test_reset_mid();
    int w;
    int n;
    set_req(0, 1'b1, 7'h12, DMI_OP_READ, 32'h0);
    push_req(0, 7'h12, DMI_OP_READ, 32'h0);
    serve_txn(0, 0, 32'h77, DMI_RESP_SUCCESS, w);
    // second transaction from 0 is abandoned in RESP
    n = 0;
    #1;
    while (dmi_req_valid !== 1'b1 && n < 20) begin
      step(); #1; n++;
    end
    checks++;
    if (dmi_req_valid !== 1'b1 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL abort_req got valid=%b id=%0d required 1 0", dmi_req_valid, grant_id);
    end
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b1;
    dmi_resp_data  = 32'hBAD0_BAD0;
    resp_ready     = 2'b11;
    reset          = 1'b1;
    step();
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== '0 || dmi_req_valid !== 1'b0 || dmi_resp_ready !== 1'b0 ||
        req_ready !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b id=%0d dv=%b drr=%b rr=%b rv=%b required all 0",
               busy, grant_id, dmi_req_valid, dmi_resp_ready, req_ready, resp_valid);
    end
    reset          = 1'b0;
    dmi_resp_valid = 1'b0;
    resp_ready     = '0;
    set_req(1, 1'b1, 7'h13, DMI_OP_WRITE, 32'h9);
    push_req(0, 7'h12, DMI_OP_READ, 32'h0);
    serve_txn(0, 0, 32'h88, DMI_RESP_SUCCESS, w);
    req_valid = '0;
  endtask

`ifdef DMI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    apply_reset();
    set_req(0, 1'b1, 7'h22, DMI_OP_READ, 32'h0);
    w = 0;
    #1;
    while (dmi_req_valid !== 1'b1 && w < 20) begin
      step(); #1; w++;
    end
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    req_valid     = '0;
    w = 0;
    #1;
    while (resp_valid[0] !== 1'b1 && w < 40) begin
      step(); #1; w++;
    end
    checks++;
    if (w !== TO || resp_valid !== 2'b01) begin
      errors++;
      $display("FAIL to_delay got %0d cycles valid=%b required %0d 01", w, resp_valid, TO);
    end
    checks++;
    if (resp_resp !== 2'd2 || resp_data !== '0 || dmi_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL to_resp got resp=%0d data=%h drr=%b required 2 0 0", resp_resp, resp_data, dmi_resp_ready);
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    #1;
    checks++;
    if (dmi_resp_ready !== 1'b1 || busy !== 1'b1 || resp_valid !== '0) begin
      errors++;
      $display("FAIL drain got drr=%b busy=%b rv=%b required 1 1 00", dmi_resp_ready, busy, resp_valid);
    end
    dmi_resp_valid = 1'b1;
    dmi_resp_data  = 32'hFEED_0001;
    resp_ready     = 2'b11;
    #1;
    checks++;
    if (resp_valid !== '0) begin
      errors++; $display("FAIL drain_leak got rv=%b required 00", resp_valid);
    end
    step();
    dmi_resp_valid = 1'b0;
    resp_ready     = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0) begin
      errors++; $display("FAIL drain_exit got busy=%b rv=%b required 0 00", busy, resp_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_req_stall();
    test_resp_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef DMI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got req=%0d rsp=%0d required 0 0", exp_req_q.size(), exp_rsp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
